simple_comp: RTL and testbench
==============================

Name: simple_comp

Overview:
- Small pipelined arithmetic datapath that computes d_out = (a_in + b_in) * c_in.
- Result is truncated to the output width by default, or saturated when the optional feature is compiled in.
- Two register stages; used as a leaf compute block fed by registered 16-bit operands.
- Carries no handshake: a new operand set is accepted every clock.

Parameters:
- WIDTH, 16, width of a_in, b_in, c_in and d_out.
- SHIFT, 0, number of LSBs dropped from the full product before truncation or saturation (fixed-point scaling); legal range 0..WIDTH.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset; clears all pipeline state.
- a_in  in  WIDTH  unsigned addend A.
- b_in  in  WIDTH  unsigned addend B.
- c_in  in  WIDTH  unsigned multiplier C.
- d_out  out  WIDTH  registered result.

Behaviour:
- Interface (already decided): one clock, port clock; reset port rst is asynchronous and active-high.
- While rst=1: s1_sum, s1_c and d_out are all forced to 0 immediately, with no clock required. First capture happens on the first rising edge after rst deasserts.
- Stage 1, every rising edge:
  - s1_sum <= a_in + b_in, computed at WIDTH+1 bits so the carry is never lost.
  - s1_c <= c_in.
- Stage 2, every rising edge:
  - p = s1_sum * s1_c, full 2*WIDTH+1 bits, unsigned.
  - q = p >> SHIFT.
  - d_out <= q[WIDTH-1:0] (wrap), or saturated per the optional feature.
- Latency: operands sampled at edge N appear on d_out after edge N+1. Throughput is 1 result per cycle, with no bubbles and no stall.
- d_out is a pure register output, with no combinational path from inputs.
- All arithmetic is unsigned; no sign extension anywhere.
- Boundary conditions:
  - a_in + b_in overflow: carry kept in the 17-bit sum; no wrap at stage 1.
  - Zero operand: c_in=0, or a_in=b_in=0, gives d_out=0 two edges later.
  - Reset mid-stream: in-flight data is discarded. d_out stays 0 until the second edge after release; the first edge loads stage 1 only.
- Operand changes between edges have no effect; only the values at the rising edge are sampled.

Optional Feature:
- Macro: SIMPLE_COMP_SAT_EN.
- Defined: if q exceeds 2^WIDTH-1, d_out <= all ones (0xFFFF for WIDTH=16); otherwise d_out <= q.
- Undefined (default): d_out <= q[WIDTH-1:0], plain modulo-2^WIDTH truncation, no overflow indication.
- No port change in either build.

Test Plan:
- Reset: hold rst=1 for 20 ns with a=b=c=0x0FFF on the inputs, then release.
  - d_out=0x0000 throughout reset.
  - d_out=0x0000 after the first post-reset edge.
  - Result appears after the second post-reset edge.
- Zero operands: a=b=c=0x0000 after reset -> d_out=0x0000 at every edge.
- Large operands: a=b=c=0x0FFF.
  - Full product is 0x1FFC002.
  - Wrap build: d_out=0xC002 two edges later.
  - SAT build: d_out=0xFFFF.
- Zero addends: a=b=0x0000, c=0x0FFF, applied one cycle after the 0x0FFF set.
  - d_out shows 0xC002 (or 0xFFFF in the SAT build) for one edge.
  - Then d_out=0x0000 on the next edge, proving back-to-back throughput.
- Mid-range operands: a=b=c=0x0666.
  - Full product is 0x51E148.
  - Wrap build: d_out=0xE148.
  - SAT build: d_out=0xFFFF.
- Small values and reset mid-stream:
  - a=1, b=2, c=3 -> d_out=0x0009 two edges later.
  - With SHIFT=1, d_out=0x0004.
  - Asserting rst mid-stream forces d_out=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/simple_comp.sv
// Two-stage unsigned datapath: d_out = ((a_in + b_in) * c_in) >> SHIFT, truncated to WIDTH bits.
// Define SIMPLE_COMP_SAT_EN to clamp to all ones instead of wrapping when the scaled product overflows.
module simple_comp #(
  parameter int WIDTH = 16,
  parameter int SHIFT = 0
) (
  input  logic             clock,
  input  logic             rst,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic [WIDTH-1:0] c_in,
  output logic [WIDTH-1:0] d_out
);

  logic [WIDTH:0]   s1_sum;
  logic [WIDTH-1:0] s1_c;
  logic [2*WIDTH:0] p;
  logic [WIDTH-1:0] q_lo;
  logic [WIDTH-1:0] d_next;

  // Both operands are zero-extended to the full product width so no bits are lost.
  assign p    = {{WIDTH{1'b0}}, s1_sum} * {{(WIDTH+1){1'b0}}, s1_c};
  assign q_lo = WIDTH'(p >> SHIFT);

`ifdef SIMPLE_COMP_SAT_EN
  logic q_ovf;
  assign q_ovf  = |(p >> (SHIFT + WIDTH));
  assign d_next = q_ovf ? {WIDTH{1'b1}} : q_lo;
`else
  assign d_next = q_lo;
`endif

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      s1_sum <= '0;
      s1_c   <= '0;
      d_out  <= '0;
    end else begin
      s1_sum <= {1'b0, a_in} + {1'b0, b_in};
      s1_c   <= c_in;
      d_out  <= d_next;
    end
  end

endmodule

// File: tb/tb_simple_comp.sv
// Self-checking bench for simple_comp: reset behaviour, a table of operand vectors
// through a scoreboard, and a reset applied mid-stream. Checks a SHIFT=0 and a SHIFT=1 instance.
module tb_simple_comp;

  logic        clock;
  logic        rst;
  logic [15:0] a_in, b_in, c_in;
  logic [15:0] d_out, d_out_s1;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] c;
    logic [15:0] exp_wrap;
    logic [15:0] exp_sat;
  } vec_t;

  typedef struct {
    logic [15:0] e0;
    logic [15:0] e1;
  } exp_t;

  vec_t vecs[14];
  exp_t sb[$];

  simple_comp #(.WIDTH(16), .SHIFT(0)) dut (
    .clock(clock), .rst(rst), .a_in(a_in), .b_in(b_in), .c_in(c_in), .d_out(d_out)
  );

  simple_comp #(.WIDTH(16), .SHIFT(1)) dut_s1 (
    .clock(clock), .rst(rst), .a_in(a_in), .b_in(b_in), .c_in(c_in), .d_out(d_out_s1)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  function automatic logic [15:0] model(input logic [15:0] a, input logic [15:0] b,
                                        input logic [15:0] c, input int sh);
    logic [63:0] full;
    full = (64'(a) + 64'(b)) * 64'(c);
    full = full >> sh;
`ifdef SIMPLE_COMP_SAT_EN
    return (full > 64'hFFFF) ? 16'hFFFF : full[15:0];
`else
    return full[15:0];
`endif
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Called at a falling edge: retire the result that is due, drive new operands, advance one cycle.
  task automatic step(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c,
                      input logic [15:0] exp0);
    exp_t e;
    if (sb.size() == 2) begin
      e = sb.pop_front();
      check("d_out_pipe", d_out, e.e0);
      check("d_out_s1_pipe", d_out_s1, e.e1);
    end
    a_in = a;
    b_in = b;
    c_in = c;
    e.e0 = exp0;
    e.e1 = model(a, b, c, 1);
    sb.push_back(e);
    @(negedge clock);
  endtask

  initial begin
    logic [15:0] e0;

    vecs[0]  = '{16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
    vecs[1]  = '{16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
    vecs[2]  = '{16'h0FFF, 16'h0FFF, 16'h0FFF, 16'hC002, 16'hFFFF};
    vecs[3]  = '{16'h0000, 16'h0000, 16'h0FFF, 16'h0000, 16'h0000};
    vecs[4]  = '{16'h0666, 16'h0666, 16'h0666, 16'hE148, 16'hFFFF};
    vecs[5]  = '{16'h0001, 16'h0002, 16'h0003, 16'h0009, 16'h0009};
    vecs[6]  = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h0002, 16'hFFFF};
    vecs[7]  = '{16'h8000, 16'h8000, 16'h0001, 16'h0000, 16'hFFFF};
    vecs[8]  = '{16'h1234, 16'h0010, 16'h0002, 16'h2488, 16'h2488};
    vecs[9]  = '{16'h7FFF, 16'h0001, 16'h0001, 16'h8000, 16'h8000};
    vecs[10] = '{16'h00FF, 16'h0000, 16'h0101, 16'hFFFF, 16'hFFFF};
    vecs[11] = '{16'h0080, 16'h0080, 16'h0100, 16'h0000, 16'hFFFF};
    vecs[12] = '{16'h0000, 16'h0000, 16'hFFFF, 16'h0000, 16'h0000};
    vecs[13] = '{16'hFFFF, 16'h0001, 16'h0003, 16'h0000, 16'hFFFF};

    // Reset with live operands on the inputs
    rst  = 1'b1;
    a_in = 16'h0FFF;
    b_in = 16'h0FFF;
    c_in = 16'h0FFF;
    #1;
    check("reset_d_out_t1", d_out, 16'h0000);
    check("reset_d_out_s1_t1", d_out_s1, 16'h0000);
    @(negedge clock);
    check("reset_d_out_t10", d_out, 16'h0000);
    @(negedge clock);
    check("reset_d_out_t20", d_out, 16'h0000);
    rst = 1'b0;
    @(negedge clock);
    check("post_reset_edge1", d_out, 16'h0000);
    check("post_reset_edge1_s1", d_out_s1, 16'h0000);
    @(negedge clock);
    check("post_reset_edge2", d_out, model(16'h0FFF, 16'h0FFF, 16'h0FFF, 0));
    check("post_reset_edge2_s1", d_out_s1, model(16'h0FFF, 16'h0FFF, 16'h0FFF, 1));

    for (int i = 0; i < 14; i++) begin
`ifdef SIMPLE_COMP_SAT_EN
      e0 = vecs[i].exp_sat;
`else
      e0 = vecs[i].exp_wrap;
`endif
      step(vecs[i].a, vecs[i].b, vecs[i].c, e0);
    end

    // Small values, then reset while they are in flight
    for (int i = 0; i < 3; i++) step(16'h0001, 16'h0002, 16'h0003, 16'h0009);
    for (int i = 0; i < 2; i++) begin
      exp_t e;
      e = sb.pop_front();
      check("d_out_drain", d_out, e.e0);
      check("d_out_s1_drain", d_out_s1, e.e1);
      @(negedge clock);
    end
    #2;
    rst = 1'b1;
    #1;
    check("midstream_reset_async", d_out, 16'h0000);
    check("midstream_reset_async_s1", d_out_s1, 16'h0000);
    sb.delete();
    @(negedge clock);
    rst = 1'b0;
    @(negedge clock);
    check("midstream_release_edge1", d_out, 16'h0000);
    check("midstream_release_edge1_s1", d_out_s1, 16'h0000);
    @(negedge clock);
    check("midstream_release_edge2", d_out, 16'h0009);
    check("midstream_release_edge2_s1", d_out_s1, 16'h0004);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
